// File: rtl/grey_incr_arb.sv
// Round-robin arbiter sharing one W-bit Gray-code counter between NREQ requesters.
// Optional sticky wrap flag enabled by defining GREY_INCR_ARB_OVF_EN.
module grey_incr_arb #(
   parameter int NREQ = 4,
   parameter int W    = 6
) (
   input  logic            clk,
   input  logic            w_rst,
   input  logic [NREQ-1:0] req,
   input  logic            hold,
   input  logic [W-1:0]    term,
   input  logic            ovf_clr,
   output logic [NREQ-1:0] ack,
   output logic [W-1:0]    grey,
   output logic            wrap,
   output logic            ovf
);

   localparam int PW = $clog2(NREQ);

   logic [W-1:0]    b;
   logic [PW-1:0]   p;
   logic [NREQ-1:0] e;
   logic            grant;
   logic            hi_found;
   logic [PW-1:0]   hi_idx;
   logic [PW-1:0]   lo_idx;
   logic [PW-1:0]   winner;
   logic            wrap_next;
   logic [W-1:0]    b_next;
   logic [W-1:0]    grey_next;

   // A requester acked this cycle sits out one cycle, so a held req cannot win twice in a row.
   assign e     = req & ~ack;
   assign grant = ~hold & (|e);

   // Round-robin: the lowest set index above p wins; otherwise wrap around to the lowest set index.
   // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (e[j]) begin
            if (j > int'(p)) begin
               hi_found = 1'b1;
               hi_idx   = PW'(j);
            end else begin
               lo_idx   = PW'(j);
            end
         end
      end
   end

   assign winner    = hi_found ? hi_idx : lo_idx;
   assign wrap_next = (b >= term);
   assign b_next    = wrap_next ? '0 : b + W'(1);
   assign grey_next = b_next ^ (b_next >> 1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         b    <= '0;
         p    <= PW'(NREQ - 1);
         ack  <= '0;
         grey <= '0;
         wrap <= 1'b0;
      end else if (grant) begin
         b    <= b_next;
         p    <= winner;
         ack  <= NREQ'(1) << winner;
         grey <= grey_next;
         wrap <= wrap_next;
      end else begin
         ack  <= '0;
         wrap <= 1'b0;
      end
   end

`ifdef GREY_INCR_ARB_OVF_EN
   // Set has priority over clear so a wrap coinciding with ovf_clr is never lost.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         ovf <= 1'b0;
      end else if (wrap) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_grey_incr_arb.sv
// Directed self-checking bench for grey_incr_arb (NREQ=4, W=6).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_grey_incr_arb;

   localparam int NREQ = 4;
   localparam int W    = 6;
`ifdef GREY_INCR_ARB_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic            clk;
   logic            w_rst;
   logic [NREQ-1:0] req;
   logic            hold;
   logic [W-1:0]    term;
   logic            ovf_clr;
   logic [NREQ-1:0] ack;
   logic [W-1:0]    grey;
   logic            wrap;
   logic            ovf;

   int n_checks = 0;
   int n_errors = 0;

   grey_incr_arb #(.NREQ(NREQ), .W(W)) dut (
      .clk     (clk),
      .w_rst   (w_rst),
      .req     (req),
      .hold    (hold),
      .term    (term),
      .ovf_clr (ovf_clr),
      .ack     (ack),
      .grey    (grey),
      .wrap    (wrap),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      w_rst = 1'b1;
      step();
      w_rst = 1'b0;
   endtask

   // Tables for the directed sequences
   logic [3:0] t1_ack  [6]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
   logic [5:0] t1_grey [6]  = '{6'd1, 6'd1, 6'd3, 6'd3, 6'd2, 6'd2};
   logic [3:0] t2_ack  [8]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
   logic [5:0] t2_grey [8]  = '{6'd1, 6'd3, 6'd2, 6'd6, 6'd7, 6'd5, 6'd4, 6'd12};
   logic [5:0] t3_grey [12] = '{6'd1, 6'd1, 6'd3, 6'd3, 6'd2, 6'd2, 6'd6, 6'd6, 6'd7, 6'd7, 6'd0, 6'd0};

   initial begin
      logic [W-1:0] prev;
      w_rst   = 1'b1;
      req     = '0;
      hold    = 1'b0;
      term    = 6'd63;
      ovf_clr = 1'b0;
      step();
      step();
      w_rst = 1'b0;

      check("rst_ack",  32'(ack),  32'h0);
      check("rst_grey", 32'(grey), 32'h0);
      check("rst_wrap", 32'(wrap), 32'h0);
      check("rst_ovf",  32'(ovf),  32'h0);

      // Single requester: one grant every other cycle
      req = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("single_ack%0d", i),  32'(ack),  32'(t1_ack[i]));
         check($sformatf("single_grey%0d", i), 32'(grey), 32'(t1_grey[i]));
         check($sformatf("single_wrap%0d", i), 32'(wrap), 32'h0);
      end

      // All requesting: strict rotation, one grant per cycle, one-bit Gray steps
      req = '0;
      do_reset();
      req  = 4'b1111;
      prev = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("rr_ack%0d", i),  32'(ack),  32'(t2_ack[i]));
         check($sformatf("rr_grey%0d", i), 32'(grey), 32'(t2_grey[i]));
         check($sformatf("rr_onebit%0d", i), 32'($countones(grey ^ prev)), 32'd1);
         prev = grey;
      end

      // term=5: wrap on the 6th grant (b 5 -> 0)
      req = '0;
      do_reset();
      term = 6'd5;
      req  = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("t5_grey%0d", i), 32'(grey), 32'(t3_grey[i]));
         check($sformatf("t5_wrap%0d", i), 32'(wrap), (i == 10) ? 32'd1 : 32'd0);
      end

      // Reach b=10, then lower term to 3 on the next grant
      req = '0;
      do_reset();
      term = 6'd63;
      req  = 4'b0011;
      for (int i = 0; i < 10; i++) step();
      check("b10_grey", 32'(grey), 32'd15);
      check("b10_ack",  32'(ack),  32'h2);
      req  = 4'b0001;
      term = 6'd3;
      step();
      check("lower_ack",  32'(ack),  32'h1);
      check("lower_grey", 32'(grey), 32'd0);
      check("lower_wrap", 32'(wrap), 32'd1);

      // Hold freezes grants with requests pending
      req  = 4'b0110;
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("hold_ack%0d", i),  32'(ack),  32'h0);
         check($sformatf("hold_grey%0d", i), 32'(grey), 32'd0);
         check($sformatf("hold_wrap%0d", i), 32'(wrap), 32'd0);
      end
      hold = 1'b0;
      step();
      check("release_ack",  32'(ack),  32'h2);
      check("release_grey", 32'(grey), 32'd1);
      check("release_wrap", 32'(wrap), 32'd0);
      step();
      check("next_ack",  32'(ack),  32'h4);
      check("next_grey", 32'(grey), 32'd3);

      // Reset mid-stream with requests still active
      w_rst = 1'b1;
      step();
      check("midrst_ack",  32'(ack),  32'h0);
      check("midrst_grey", 32'(grey), 32'd0);
      check("midrst_wrap", 32'(wrap), 32'd0);
      check("midrst_ovf",  32'(ovf),  32'd0);
      w_rst = 1'b0;
      step();
      check("postrst_ack",  32'(ack),  32'h2);
      check("postrst_grey", 32'(grey), 32'd1);

      // Sticky overflow: set, set-beats-clear, clear alone
      req = '0;
      do_reset();
      term = 6'd0;
      req  = 4'b0001;
      step();
      check("ovf_w1_ack",  32'(ack),  32'h1);
      check("ovf_w1_wrap", 32'(wrap), 32'd1);
      check("ovf_w1_grey", 32'(grey), 32'd0);
      check("ovf_w1_ovf",  32'(ovf),  32'd0);
      step();
      check("ovf_set_wrap", 32'(wrap), 32'd0);
      check("ovf_set",      32'(ovf),  32'(OVF_ON));
      step();
      check("ovf_w2_wrap", 32'(wrap), 32'd1);
      check("ovf_w2_ovf",  32'(ovf),  32'(OVF_ON));
      ovf_clr = 1'b1;
      req     = '0;
      step();
      check("ovf_setwins", 32'(ovf),  32'(OVF_ON));
      check("ovf_nowrap",  32'(wrap), 32'd0);
      step();
      check("ovf_cleared", 32'(ovf), 32'd0);
      ovf_clr = 1'b0;
      step();
      check("ovf_stays0", 32'(ovf), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
